// File: rtl/spi_dac_tx.sv
// Serial transmitter for a 12-bit SPI DAC: buffers one audio sample and ships it as a
// 16-bit mode-0 frame, then strobes LDAC to latch the new code into the output.
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | no frame; load shift register when the buffer is full
// SETUP    | cs_n low, first bit on mosi, waiting before first sck rise
// SHIFT_HI | sck high, DAC samples the current bit
// SHIFT_LO | sck low, next bit presented (or frame finishing)
// GAP      | cs_n released, waiting before the latch strobe
// LATCH    | ldac_n held low
module spi_dac_tx #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CHANNEL = 0,
    parameter int unsigned GAIN_1X = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sample_valid,
    input  logic [15:0] sample,
    output logic        ready,
    output logic        busy,
    output logic        overrun,
    output logic        dac_cs_n,
    output logic        dac_sck,
    output logic        dac_mosi,
    output logic        dac_ldac_n
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_HI,
        SHIFT_LO,
        GAP,
        LATCH
    } state_t;

    localparam logic [7:0] PH_LOAD  = 8'(CLK_DIV - 1);
    localparam logic       CH_BIT   = 1'(CHANNEL);
    localparam logic       GAIN_BIT = 1'(GAIN_1X);

    state_t      state;
    logic [11:0] buf_data;
    logic        buf_full;
    logic [14:0] shreg;
    logic [7:0]  phase_cnt;
    logic [4:0]  bit_cnt;
    logic        drain;
    logic        phase_done;
    logic        unused_lsbs;

    assign drain       = (state == IDLE) && buf_full;
    assign phase_done  = (phase_cnt == 8'd0);
    assign ready       = ~buf_full;
    assign busy        = (state != IDLE);
    assign unused_lsbs = ^sample[3:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            buf_data   <= '0;
            buf_full   <= 1'b0;
            shreg      <= '0;
            phase_cnt  <= '0;
            bit_cnt    <= '0;
            overrun    <= 1'b0;
            dac_cs_n   <= 1'b1;
            dac_sck    <= 1'b0;
            dac_mosi   <= 1'b0;
            dac_ldac_n <= 1'b1;
        end else begin
            // A sample landing on the drain edge refills the just-emptied buffer.
            overrun <= sample_valid && buf_full && !drain;
            if (sample_valid) begin
                buf_data <= sample[15:4];
                buf_full <= 1'b1;
            end else if (drain) begin
                buf_full <= 1'b0;
            end

            if (state != IDLE) begin
                phase_cnt <= phase_done ? PH_LOAD : phase_cnt - 8'd1;
            end

            case (state)
                IDLE: begin
                    if (buf_full) begin
                        shreg     <= {1'b0, GAIN_BIT, 1'b1, buf_data};
                        dac_mosi  <= CH_BIT;
                        dac_cs_n  <= 1'b0;
                        phase_cnt <= PH_LOAD;
                        bit_cnt   <= 5'd16;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_done) begin
                        dac_sck <= 1'b1;
                        state   <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (phase_done) begin
                        dac_sck <= 1'b0;
                        bit_cnt <= bit_cnt - 5'd1;
                        // Next bit goes out on the falling edge so it is settled a full
                        // half-period before the DAC samples it.
                        if (bit_cnt != 5'd1) begin
                            dac_mosi <= shreg[14];
                            shreg    <= {shreg[13:0], 1'b0};
                        end
                        state <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (phase_done) begin
                        if (bit_cnt == 5'd0) begin
                            dac_cs_n <= 1'b1;
                            dac_mosi <= 1'b0;
                            state    <= GAP;
                        end else begin
                            dac_sck <= 1'b1;
                            state   <= SHIFT_HI;
                        end
                    end
                end
                GAP: begin
                    if (phase_done) begin
                        dac_ldac_n <= 1'b0;
                        state      <= LATCH;
                    end
                end
                LATCH: begin
                    if (phase_done) begin
                        dac_ldac_n <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
